// File: rtl/icache_dm.sv
// ----------------------------------------------------------------------------
// icache_dm -- direct-mapped, read-only instruction cache.
//
// Sits between the core fetch stage and the instruction port of the
// simulation RAM. Hits are answered two cycles after the request (one lookup
// cycle plus a registered response). On a miss the whole line is fetched with
// one single-word strobe/done transaction per word, then the requested word is
// returned.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   p_strobe_i    fetch request pulse (ignored while p_busy_o=1)
//   p_addr_i      fetch byte address (bits [1:0] ignored)
//   p_instr_o     fetched word, valid while p_ready_o=1, held otherwise
//   p_ready_o     one-cycle response pulse
//   p_busy_o      high while a request is outstanding
//   flush_i       invalidate-all pulse (deferred to the next return to IDLE
//                 when it arrives during a request)
//   m_strobe_o    RAM read request pulse
//   m_addr_o      RAM word byte address
//   m_rdata_i     RAM read data (valid the cycle before m_done_i)
//   m_done_i      RAM completion pulse
//   hit_cnt_o     saturating hit counter
//   miss_cnt_o    saturating miss counter
// ----------------------------------------------------------------------------
module icache_dm #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LINES          = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p_strobe_i,
  input  logic [ADDR_WIDTH-1:0] p_addr_i,
  output logic [DATA_WIDTH-1:0] p_instr_o,
  output logic                  p_ready_o,
  output logic                  p_busy_o,
  input  logic                  flush_i,
  output logic                  m_strobe_o,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  input  logic [DATA_WIDTH-1:0] m_rdata_i,
  input  logic                  m_done_i,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
);

  localparam int WB  = $clog2(WORDS_PER_LINE);
  localparam int IB  = $clog2(LINES);
  localparam int OFF = WB + 2;
  localparam int TW  = ADDR_WIDTH - OFF - IB;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FILL_REQ,
    FILL_WAIT,
    RESPOND
  } state_t;

  state_t state_reg, state_next;

  // Latched request address (word granularity) and its fields.
  logic [ADDR_WIDTH-1:2] addr_reg;
  logic [TW-1:0]         req_tag;
  logic [IB-1:0]         req_idx;
  logic [WB-1:0]         req_word;
  assign req_tag  = addr_reg[ADDR_WIDTH-1:OFF+IB];
  assign req_idx  = addr_reg[OFF+IB-1:OFF];
  assign req_word = addr_reg[OFF-1:2];

  // Fields of the incoming address, used to start the array reads on accept.
  logic [IB-1:0] in_idx;
  logic [WB-1:0] in_word;
  assign in_idx  = p_addr_i[OFF+IB-1:OFF];
  assign in_word = p_addr_i[OFF-1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^p_addr_i[1:0];

  // Storage: data and tag arrays (never reset), per-line valid bits.
  logic [DATA_WIDTH-1:0] data_mem [LINES*WORDS_PER_LINE];
  logic [TW-1:0]         tag_mem  [LINES];
  logic                  valid_reg [LINES];

  logic [DATA_WIDTH-1:0] data_rd_reg;
  logic [TW-1:0]         tag_rd_reg;

  logic [WB-1:0]         k_reg;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic [DATA_WIDTH-1:0] fill_word_reg;
  logic [DATA_WIDTH-1:0] instr_reg;
  logic                  ready_reg;
  logic                  busy_reg;
  logic [ADDR_WIDTH-1:0] m_addr_reg;
  logic [31:0]           hit_cnt_reg;
  logic [31:0]           miss_cnt_reg;
  logic                  flush_pend_reg;

  // Control decode.
  logic          accept;
  logic          hit;
  logic          lookup_hit;
  logic          lookup_miss;
  logic          fill_write;
  logic          last_word;
  logic          to_idle;
  logic          clear_valid;
  logic [WB-1:0] k_next;

  assign hit    = valid_reg[req_idx] && (tag_rd_reg == req_tag);
  assign k_next = k_reg + WB'(1);

  always_comb begin
    state_next  = state_reg;
    accept      = 1'b0;
    lookup_hit  = 1'b0;
    lookup_miss = 1'b0;
    fill_write  = 1'b0;
    last_word   = (k_reg == WB'(WORDS_PER_LINE - 1));
    to_idle     = 1'b0;
    m_strobe_o  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (p_strobe_i) begin
          accept     = 1'b1;
          state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          lookup_hit = 1'b1;
          to_idle    = 1'b1;
          state_next = IDLE;
        end else begin
          lookup_miss = 1'b1;
          state_next  = FILL_REQ;
        end
      end
      FILL_REQ: begin
        // Strobe is a pure decode of a one-cycle state, so it can never be
        // held across consecutive cycles.
        m_strobe_o = 1'b1;
        state_next = FILL_WAIT;
      end
      FILL_WAIT: begin
        if (m_done_i) begin
          fill_write = 1'b1;
          state_next = last_word ? RESPOND : FILL_REQ;
        end
      end
      RESPOND: begin
        to_idle    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A flush in IDLE lands before the lookup of a same-cycle request; a
    // flush seen during a request waits until the request completes and then
    // also wipes the line that request may have just filled.
    clear_valid = ((state_reg == IDLE) && flush_i) ||
                  (to_idle && (flush_pend_reg || flush_i));
  end

  // Array access: registered reads launched on accept, writes during fill.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_rd_reg <= data_mem[{in_idx, in_word}];
      tag_rd_reg  <= tag_mem[in_idx];
    end
    if (fill_write) begin
      data_mem[{req_idx, k_reg}] <= hold_reg;
    end
    if (fill_write && last_word) begin
      tag_mem[req_idx] <= req_tag;
    end
  end

  // Valid bits: one flop per line.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    always_ff @(posedge clk) begin
      if (rst || clear_valid) begin
        valid_reg[gi] <= 1'b0;
      end else if (fill_write && last_word && (req_idx == IB'(gi))) begin
        valid_reg[gi] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      k_reg          <= '0;
      hold_reg       <= '0;
      fill_word_reg  <= '0;
      instr_reg      <= '0;
      ready_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      m_addr_reg     <= '0;
      hit_cnt_reg    <= '0;
      miss_cnt_reg   <= '0;
      flush_pend_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= 1'b0;
      // RAM data leads m_done_i by one cycle, so capture it unconditionally.
      hold_reg  <= m_rdata_i;

      if (accept) begin
        addr_reg <= p_addr_i[ADDR_WIDTH-1:2];
        busy_reg <= 1'b1;
      end

      if (lookup_hit) begin
        instr_reg <= data_rd_reg;
        ready_reg <= 1'b1;
        busy_reg  <= 1'b0;
        if (hit_cnt_reg != '1) begin
          hit_cnt_reg <= hit_cnt_reg + 32'd1;
        end
      end

      if (lookup_miss) begin
        k_reg      <= '0;
        m_addr_reg <= {req_tag, req_idx, {WB{1'b0}}, 2'b00};
        if (miss_cnt_reg != '1) begin
          miss_cnt_reg <= miss_cnt_reg + 32'd1;
        end
      end

      if (fill_write) begin
        // Keep the requested word aside: the array read port would return
        // stale data for a word written on the same edge.
        if (k_reg == req_word) begin
          fill_word_reg <= hold_reg;
        end
        if (!last_word) begin
          k_reg      <= k_next;
          m_addr_reg <= {req_tag, req_idx, k_next, 2'b00};
        end
      end

      if (state_reg == RESPOND) begin
        instr_reg <= fill_word_reg;
        ready_reg <= 1'b1;
        busy_reg  <= 1'b0;
      end

      if (to_idle) begin
        flush_pend_reg <= 1'b0;
      end else if (flush_i && (state_reg != IDLE)) begin
        flush_pend_reg <= 1'b1;
      end
    end
  end

  assign p_instr_o  = instr_reg;
  assign p_ready_o  = ready_reg;
  assign p_busy_o   = busy_reg;
  assign m_addr_o   = m_addr_reg;
  assign hit_cnt_o  = hit_cnt_reg;
  assign miss_cnt_o = miss_cnt_reg;

endmodule

// File: tb/tb_icache_dm.sv
// ----------------------------------------------------------------------------
// tb_icache_dm -- directed bench for icache_dm.
// A behavioural RAM answers each m_strobe_o after a programmable latency:
// data appears one cycle before m_done_i, and is replaced by garbage in the
// m_done_i cycle itself.
// ----------------------------------------------------------------------------
module tb_icache_dm;

  logic        clk;
  logic        rst;
  logic        p_strobe;
  logic [31:0] p_addr;
  logic [31:0] p_instr;
  logic        p_ready;
  logic        p_busy;
  logic        flush;
  logic        m_strobe;
  logic [31:0] m_addr;
  logic [31:0] m_rdata;
  logic        m_done;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          ram_lat   = 0;
  logic [31:0] strobe_q[$];

  icache_dm dut (
    .clk        (clk),
    .rst        (rst),
    .p_strobe_i (p_strobe),
    .p_addr_i   (p_addr),
    .p_instr_o  (p_instr),
    .p_ready_o  (p_ready),
    .p_busy_o   (p_busy),
    .flush_i    (flush),
    .m_strobe_o (m_strobe),
    .m_addr_o   (m_addr),
    .m_rdata_i  (m_rdata),
    .m_done_i   (m_done),
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    case (a)
      32'h100: memval = 32'h11;
      32'h104: memval = 32'h22;
      32'h108: memval = 32'h33;
      32'h10C: memval = 32'h44;
      default: memval = 32'hA000_0000 | a;
    endcase
  endfunction

  // RAM responder, acting on falling edges.
  initial begin
    logic [31:0] a;
    m_done  = 1'b0;
    m_rdata = 32'h0;
    forever begin
      @(negedge clk);
      m_done = 1'b0;
      if (m_strobe) begin
        a = m_addr;
        strobe_q.push_back(a);
        repeat (ram_lat) @(negedge clk);
        @(negedge clk);
        m_rdata = memval(a);
        @(negedge clk);
        m_rdata = 32'hDEAD_BEEF;
        m_done  = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic start(input logic [31:0] a, input logic fl);
    p_addr   = a;
    p_strobe = 1'b1;
    flush    = fl;
    tick();
    p_strobe = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic wait_ready(input string tag, output logic [31:0] instr);
    int n = 0;
    while (!p_ready && n < 300) begin
      tick();
      n++;
    end
    if (!p_ready) begin
      total_cnt++;
      $error("FAIL %s: observed no p_ready_o expected p_ready_o within 300 cycles", tag);
    end
    instr = p_instr;
  endtask

  task automatic wait_strobes(input string tag, input int cnt);
    int n = 0;
    while (strobe_q.size() < cnt && n < 300) begin
      tick();
      n++;
    end
    if (strobe_q.size() < cnt) begin
      total_cnt++;
      $error("FAIL %s: observed %0d strobes expected %0d", tag, strobe_q.size(), cnt);
    end
  endtask

  // Full miss: one line fill of 4 word-aligned strobes, then the response.
  task automatic fetch_miss(input string tag, input logic [31:0] a, input logic fl,
                            input logic [31:0] exp_miss);
    logic [31:0] instr;
    logic [31:0] base;
    strobe_q.delete();
    start(a, fl);
    wait_ready(tag, instr);
    $display("fetch %h flush=%0b -> instr %h miss=%0d hit=%0d strobes=%0d",
             a, fl, instr, miss_cnt, hit_cnt, strobe_q.size());
    chk({tag, "_instr"}, instr, memval(a));
    chk({tag, "_nstrobe"}, 32'(strobe_q.size()), 32'd4);
    chk({tag, "_miss"}, miss_cnt, exp_miss);
    base = a & 32'hFFFF_FFF0;
    for (int i = 0; i < 4 && i < strobe_q.size(); i++) begin
      chk({tag, "_maddr"}, strobe_q[i], base + 32'(4 * i));
    end
  endtask

  initial begin
    logic [31:0] instr;
    bit          saw_done;
    bit          saw_ready;
    bit          saw_busy;
    int          n;

    rst      = 1'b1;
    p_strobe = 1'b0;
    p_addr   = 32'h0;
    flush    = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state.
    $display("reset: ready=%0b busy=%0b instr=%h mstrobe=%0b maddr=%h hit=%0d miss=%0d",
             p_ready, p_busy, p_instr, m_strobe, m_addr, hit_cnt, miss_cnt);
    chk("rst_ready", 32'(p_ready), 32'd0);
    chk("rst_busy", 32'(p_busy), 32'd0);
    chk("rst_instr", p_instr, 32'h0);
    chk("rst_mstrobe", 32'(m_strobe), 32'd0);
    chk("rst_maddr", m_addr, 32'h0);
    chk("rst_hit", hit_cnt, 32'd0);
    chk("rst_miss", miss_cnt, 32'd0);

    // Cold miss, zero RAM latency.
    fetch_miss("cold", 32'h108, 1'b0, 32'd1);
    chk("cold_busy", 32'(p_busy), 32'd0);
    chk("cold_hit", hit_cnt, 32'd0);

    // Hit after fill: ready exactly two cycles after the strobe cycle.
    strobe_q.delete();
    start(32'h10C, 1'b0);
    chk("hit_ready_t1", 32'(p_ready), 32'd0);
    chk("hit_busy_t1", 32'(p_busy), 32'd1);
    tick();
    $display("fetch 0000010c -> ready=%0b instr=%h hit=%0d", p_ready, p_instr, hit_cnt);
    chk("hit_ready_t2", 32'(p_ready), 32'd1);
    chk("hit_instr", p_instr, 32'h44);
    chk("hit_busy_t2", 32'(p_busy), 32'd0);
    chk("hit_cnt", hit_cnt, 32'd1);
    tick();
    chk("hit_ready_pulse", 32'(p_ready), 32'd0);
    chk("hit_instr_hold", p_instr, 32'h44);
    chk("hit_nstrobe", 32'(strobe_q.size()), 32'd0);

    // Flush in IDLE, then conflict eviction on index 16.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    $display("flush in idle");
    fetch_miss("conf_a", 32'h100, 1'b0, 32'd2);
    fetch_miss("conf_b", 32'h500, 1'b0, 32'd3);
    fetch_miss("conf_c", 32'h100, 1'b0, 32'd4);

    // Flush during fill: correct word returned, then line is gone.
    ram_lat = 2;
    strobe_q.delete();
    start(32'h204, 1'b0);
    wait_strobes("fl_strobe", 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_ready("fl_first", instr);
    $display("fetch 00000204 with flush during fill -> instr %h miss=%0d", instr, miss_cnt);
    chk("fl_first_instr", instr, 32'hA000_0204);
    chk("fl_first_miss", miss_cnt, 32'd5);
    fetch_miss("fl_second", 32'h204, 1'b0, 32'd6);

    // Reset mid-fill; stale m_done_i arrives after reset is released.
    ram_lat = 4;
    strobe_q.delete();
    start(32'h300, 1'b0);
    wait_strobes("rmf_strobe", 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("reset mid-fill: busy=%0b mstrobe=%0b miss=%0d", p_busy, m_strobe, miss_cnt);
    chk("rmf_busy", 32'(p_busy), 32'd0);
    chk("rmf_mstrobe", 32'(m_strobe), 32'd0);
    chk("rmf_miss", miss_cnt, 32'd0);
    saw_done  = 1'b0;
    saw_ready = 1'b0;
    saw_busy  = 1'b0;
    n = 0;
    while (!saw_done && n < 20) begin
      tick();
      n++;
      if (m_done) saw_done = 1'b1;
      if (p_ready) saw_ready = 1'b1;
      if (p_busy) saw_busy = 1'b1;
    end
    if (!saw_done) begin
      total_cnt++;
      $error("FAIL rmf_stale: observed no stale m_done_i expected one within 20 cycles");
    end
    repeat (3) begin
      tick();
      if (p_ready) saw_ready = 1'b1;
      if (p_busy) saw_busy = 1'b1;
    end
    $display("stale done: ready_seen=%0b busy_seen=%0b", saw_ready, saw_busy);
    chk("rmf_no_ready", 32'(saw_ready), 32'd0);
    chk("rmf_no_busy", 32'(saw_busy), 32'd0);
    chk("rmf_no_strobe", 32'(m_strobe), 32'd0);
    ram_lat = 0;
    fetch_miss("rmf_refill", 32'h300, 1'b0, 32'd1);

    // Extra strobe during a fill is ignored and not counted.
    strobe_q.delete();
    start(32'h400, 1'b0);
    wait_strobes("ovl_strobe", 1);
    p_addr   = 32'h10C;
    p_strobe = 1'b1;
    tick();
    p_strobe = 1'b0;
    wait_ready("ovl", instr);
    $display("fetch 00000400 with extra strobe -> instr %h miss=%0d hit=%0d strobes=%0d",
             instr, miss_cnt, hit_cnt, strobe_q.size());
    chk("ovl_instr", instr, 32'hA000_0400);
    chk("ovl_miss", miss_cnt, 32'd2);
    chk("ovl_hit", hit_cnt, 32'd0);
    repeat (4) tick();
    chk("ovl_no_2nd_ready", 32'(p_ready), 32'd0);
    chk("ovl_busy", 32'(p_busy), 32'd0);
    chk("ovl_nstrobe", 32'(strobe_q.size()), 32'd4);

    // Strobe and flush together: the flush wins, so the cached line misses.
    fetch_miss("sflush", 32'h404, 1'b1, 32'd3);
    chk("sflush_hit", hit_cnt, 32'd0);

    // Refilled line now hits.
    strobe_q.delete();
    start(32'h408, 1'b0);
    tick();
    $display("fetch 00000408 -> ready=%0b instr=%h hit=%0d", p_ready, p_instr, hit_cnt);
    chk("rehit_ready", 32'(p_ready), 32'd1);
    chk("rehit_instr", p_instr, 32'hA000_0408);
    chk("rehit_cnt", hit_cnt, 32'd1);
    chk("rehit_nstrobe", 32'(strobe_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
